player_core: RTL and testbench

//  Parametrised playback controller: N_SONGS songs, per-song address sequencing, seek, play/pause and repeat modes.

---
 rtl/player_core_if.sv | 45 ++++
 rtl/player_core.sv | 194 +++++++++++++++++++
 tb/tb_player_core.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/player_core_if.sv
// Playback controller bus: timing tick, user buttons, mode, song ROM port
// and status outputs.
//   master : the player core. It reads the tick, buttons, mode and rom_data,
//            and drives rom_addr and the status outputs.
//   slave  : the surrounding player or testbench. It drives the inputs and
//            reads the status outputs.
interface player_core_if #(
  parameter int unsigned N_SONGS   = 4,
  parameter int unsigned ADDR_W    = 22,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned ELAPSED_W = 10
);
  localparam int unsigned SEL_W = $clog2(N_SONGS);

  logic                    sample_tick;
  logic                    btn_play_pause;
  logic                    btn_next;
  logic                    btn_prev;
  logic                    btn_fwd_short;
  logic                    btn_back_short;
  logic                    btn_fwd_long;
  logic                    btn_back_long;
  logic [1:0]              mode;
  logic [DATA_W-1:0]       rom_data;
  logic [SEL_W+ADDR_W-1:0] rom_addr;
  logic [SEL_W-1:0]        song_sel;
  logic                    playing;
  logic [ELAPSED_W-1:0]    elapsed_s;
  logic                    song_start;
  logic                    end_of_list;

  modport master (
    input  sample_tick, btn_play_pause, btn_next, btn_prev,
           btn_fwd_short, btn_back_short, btn_fwd_long, btn_back_long,
           mode, rom_data,
    output rom_addr, song_sel, playing, elapsed_s, song_start, end_of_list
  );

  modport slave (
    output sample_tick, btn_play_pause, btn_next, btn_prev,
           btn_fwd_short, btn_back_short, btn_fwd_long, btn_back_long,
           mode, rom_data,
    input  rom_addr, song_sel, playing, elapsed_s, song_start, end_of_list
  );
endinterface

// File: rtl/player_core.sv
// Playback controller for N_SONGS songs.
// It sequences per-song ROM addresses on sample_tick and counts elapsed
// seconds. It also handles play/pause, next/prev, short and long seeks,
// and the four end-of-song modes.
// Ports:
//   clk   : system clock
//   reset : asynchronous, active-low
//   bus   : player_core_if master. Inputs are the tick, the buttons, mode
//           and rom_data. Outputs are rom_addr, song_sel, playing,
//           elapsed_s, song_start and end_of_list.
module player_core #(
  parameter int unsigned N_SONGS        = 4,
  parameter int unsigned ADDR_W         = 22,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned SPS            = 8000,
  parameter int unsigned SEEK_SHORT     = 10,
  parameter int unsigned SEEK_LONG      = 30,
  parameter int unsigned PREV_RESTART_S = 3,
  parameter int unsigned ELAPSED_W      = 10
) (
  input  logic          clk,
  input  logic          reset,
  player_core_if.master bus
);
  localparam int unsigned SEL_W = $clog2(N_SONGS);
  localparam int unsigned SUB_W = (SPS > 1) ? $clog2(SPS) : 1;
  localparam int unsigned DW    = ADDR_W + 1;   // seek delta width
  localparam int unsigned SW    = ADDR_W + 2;   // addr + delta without overflow
  localparam int unsigned EW1   = ELAPSED_W + 1;

  localparam logic [ADDR_W-1:0]    MAX_ADDR  = '1;
  localparam logic [DW-1:0]        DELTA_S   = DW'(SEEK_SHORT * SPS);
  localparam logic [DW-1:0]        DELTA_L   = DW'(SEEK_LONG * SPS);
  localparam logic [EW1-1:0]       SEC_S     = EW1'(SEEK_SHORT);
  localparam logic [EW1-1:0]       SEC_L     = EW1'(SEEK_LONG);
  localparam logic [EW1-1:0]       PREV_SEC  = EW1'(PREV_RESTART_S);
  localparam logic [SEL_W-1:0]     LAST_SONG = SEL_W'(N_SONGS - 1);
  localparam logic [SUB_W-1:0]     SUB_LAST  = SUB_W'(SPS - 1);
  localparam logic [ELAPSED_W-1:0] EL_MAX    = '1;

  typedef enum logic [1:0] {STOPPED, PLAYING, PAUSED} state_t;

  // Button bit order: back_long, fwd_long, back_short, fwd_short,
  // prev, next, play_pause.
  localparam int unsigned B_PP = 0, B_NEXT = 1, B_PREV = 2, B_FS = 3,
                          B_BS = 4, B_FL = 5, B_BL = 6;

  state_t               state;
  logic                 playing;
  logic [SEL_W-1:0]     song_sel;
  logic [ADDR_W-1:0]    addr;
  logic [SUB_W-1:0]     sub;
  logic [ELAPSED_W-1:0] elapsed;
  logic                 song_start;
  logic                 end_of_list;
  logic [6:0]           btn_q;

  logic [6:0]           btn, ev;
  logic                 seek_on, seek_fwd, back_under;
  logic [DW-1:0]        seek_delta;
  logic [EW1-1:0]       seek_sec, el_sum;
  logic [SW-1:0]        fwd_sum;
  logic                 fwd_over, tick_run, eos, end_evt, last;
  logic [SEL_W-1:0]     song_inc, song_dec, song_tgt;
  logic                 restart, eol;
  state_t               state_pp, state_nxt;
  logic [ELAPSED_W-1:0] el_up, el_down, el_inc;
  logic [ADDR_W-1:0]    addr_back;

  assign btn = {bus.btn_back_long, bus.btn_fwd_long, bus.btn_back_short,
                bus.btn_fwd_short, bus.btn_prev, bus.btn_next,
                bus.btn_play_pause};

  // Event decode, priority selection and next-value arithmetic
  always_comb begin
    ev         = btn & ~btn_q;
    seek_on    = 1'b0;
    seek_fwd   = 1'b0;
    seek_delta = '0;
    seek_sec   = '0;
    // Seeks are ignored while stopped; the highest-priority seek wins
    if (state != STOPPED) begin
      if (ev[B_FL]) begin
        seek_on = 1'b1; seek_fwd = 1'b1; seek_delta = DELTA_L; seek_sec = SEC_L;
      end else if (ev[B_BL]) begin
        seek_on = 1'b1; seek_delta = DELTA_L; seek_sec = SEC_L;
      end else if (ev[B_FS]) begin
        seek_on = 1'b1; seek_fwd = 1'b1; seek_delta = DELTA_S; seek_sec = SEC_S;
      end else if (ev[B_BS]) begin
        seek_on = 1'b1; seek_delta = DELTA_S; seek_sec = SEC_S;
      end
    end

    fwd_sum    = SW'(addr) + SW'(seek_delta);
    fwd_over   = fwd_sum > SW'(MAX_ADDR);
    back_under = DW'(addr) < seek_delta;
    addr_back  = ADDR_W'(DW'(addr) - seek_delta);

    el_sum  = EW1'(elapsed) + seek_sec;
    el_up   = el_sum[ELAPSED_W] ? EL_MAX : el_sum[ELAPSED_W-1:0];
    el_down = (EW1'(elapsed) >= seek_sec) ?
              ELAPSED_W'(EW1'(elapsed) - seek_sec) : '0;
    el_inc  = (elapsed == EL_MAX) ? EL_MAX : elapsed + ELAPSED_W'(1);

    tick_run = (state == PLAYING) && bus.sample_tick;
    eos      = tick_run && ((addr == MAX_ADDR) || (bus.rom_data == DATA_W'(0)));
    // A forward seek past the end counts as end of song. A winning seek
    // hides the tick-based end detect.
    end_evt  = !ev[B_NEXT] && !ev[B_PREV] &&
               (seek_on ? (seek_fwd && fwd_over) : eos);

    last     = song_sel == LAST_SONG;
    song_inc = last ? '0 : song_sel + SEL_W'(1);
    song_dec = (song_sel == '0) ? LAST_SONG : song_sel - SEL_W'(1);

    restart  = 1'b0;
    song_tgt = song_sel;
    eol      = 1'b0;
    if (ev[B_NEXT]) begin
      restart  = 1'b1;
      song_tgt = song_inc;
    end else if (ev[B_PREV]) begin
      restart  = 1'b1;
      song_tgt = ({1'b0, elapsed} >= PREV_SEC) ? song_sel : song_dec;
    end else if (end_evt) begin
      // Modes 10 and 11 stay on the same song; 00 and 01 advance with wrap
      restart  = 1'b1;
      song_tgt = bus.mode[1] ? song_sel : song_inc;
      eol      = (bus.mode == 2'b00) && last;
    end

    state_pp = state;
    if (ev[B_PP]) state_pp = (state == PLAYING) ? PAUSED : PLAYING;
    state_nxt = (end_evt && (((bus.mode == 2'b00) && last) || (bus.mode == 2'b11)))
                ? STOPPED : state_pp;
  end

  // State, song position and pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= STOPPED;
      playing     <= 1'b0;
      song_sel    <= '0;
      addr        <= '0;
      sub         <= '0;
      elapsed     <= '0;
      song_start  <= 1'b0;
      end_of_list <= 1'b0;
      btn_q       <= '0;
    end else begin
      btn_q       <= btn;
      state       <= state_nxt;
      playing     <= state_nxt == PLAYING;
      song_start  <= 1'b0;
      end_of_list <= 1'b0;
      if (restart) begin
        song_sel    <= song_tgt;
        addr        <= '0;
        sub         <= '0;
        elapsed     <= '0;
        song_start  <= 1'b1;
        end_of_list <= eol;
      end else if (seek_on) begin
        // A forward seek that overflows has already been taken as a restart
        if (seek_fwd) begin
          addr    <= fwd_sum[ADDR_W-1:0];
          elapsed <= el_up;
        end else if (back_under) begin
          addr    <= '0;
          sub     <= '0;
          elapsed <= '0;
        end else begin
          addr    <= addr_back;
          elapsed <= el_down;
        end
      end else if (tick_run) begin
        addr <= addr + ADDR_W'(1);
        if (sub == SUB_LAST) begin
          sub     <= '0;
          elapsed <= el_inc;
        end else begin
          sub <= sub + SUB_W'(1);
        end
      end
    end
  end

  assign bus.rom_addr    = {song_sel, addr};
  assign bus.song_sel    = song_sel;
  assign bus.playing     = playing;
  assign bus.elapsed_s   = elapsed;
  assign bus.song_start  = song_start;
  assign bus.end_of_list = end_of_list;
endmodule

// File: tb/tb_player_core.sv
// Testbench for player_core, built with N_SONGS=4, SPS=4 and ADDR_W=8.
// Directed stimulus pushes hand-computed expected outputs into a
// scoreboard queue. A monitor on the falling edge pops each entry and
// compares it with the DUT outputs.
module tb_player_core;
  logic clk;
  logic reset;

  player_core_if #(.N_SONGS(4), .ADDR_W(8), .DATA_W(8), .ELAPSED_W(10)) bus ();

  player_core #(
    .N_SONGS(4), .ADDR_W(8), .DATA_W(8), .SPS(4), .SEEK_SHORT(10),
    .SEEK_LONG(30), .PREV_RESTART_S(3), .ELAPSED_W(10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic        pl;
    logic [1:0]  song;
    logic [7:0]  addr;
    logic [9:0]  el;
    logic        st;
    logic        eol;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Button mask bits
  localparam logic [6:0] PP = 7'h01, NX = 7'h02, PV = 7'h04, FS = 7'h08,
                         BS = 7'h10, FL = 7'h20, BL = 7'h40;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input string name, input logic pl, input int song,
                          input int addr, input int el, input logic st,
                          input logic eol);
    exp_t e;
    e.name = name; e.pl = pl; e.song = 2'(song); e.addr = 8'(addr);
    e.el = 10'(el); e.st = st; e.eol = eol;
    sb.push_back(e);
  endtask

  task automatic set_btns(input logic [6:0] m);
    bus.btn_play_pause = m[0];
    bus.btn_next       = m[1];
    bus.btn_prev       = m[2];
    bus.btn_fwd_short  = m[3];
    bus.btn_back_short = m[4];
    bus.btn_fwd_long   = m[5];
    bus.btn_back_long  = m[6];
  endtask

  // One released cycle, then the buttons held for exactly one edge
  task automatic press(input logic [6:0] m);
    @(posedge clk); #1;
    set_btns(m);
    @(posedge clk); #1;
    set_btns(7'h00);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      bus.sample_tick = 1'b1;
      @(posedge clk); #1;
    end
    bus.sample_tick = 1'b0;
  endtask

  // From addr 0 / sub 0: 120, 240, then 15 ticks -> addr 255, elapsed 63
  task automatic goto_max();
    press(FL);
    press(FL);
    ticks(15);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if (bus.playing === e.pl && bus.song_sel === e.song &&
          bus.rom_addr === {e.song, e.addr} && bus.elapsed_s === e.el &&
          bus.song_start === e.st && bus.end_of_list === e.eol) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got play=%0b song=%0d rom_addr=%0h el=%0d start=%0b eol=%0b; want play=%0b song=%0d rom_addr=%0h el=%0d start=%0b eol=%0b",
                 e.name, bus.playing, bus.song_sel, bus.rom_addr, bus.elapsed_s,
                 bus.song_start, bus.end_of_list, e.pl, e.song, {e.song, e.addr},
                 e.el, e.st, e.eol);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    bus.sample_tick = 1'b0;
    set_btns(7'h00);
    bus.mode = 2'b00;
    bus.rom_data = 8'h5A;

    repeat (2) @(posedge clk);
    #1;
    push_exp("reset", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_exp("release", 0, 0, 0, 0, 0, 0);

    press(PP);  push_exp("play", 1, 0, 0, 0, 0, 0);
    ticks(8);   push_exp("tick8", 1, 0, 8, 2, 0, 0);
    ticks(12);  push_exp("tick20", 1, 0, 20, 5, 0, 0);
    press(BL);  push_exp("back_long", 1, 0, 0, 0, 0, 0);
    press(FS);  push_exp("fwd_short", 1, 0, 40, 10, 0, 0);
    press(BS);  push_exp("back_short", 1, 0, 0, 0, 0, 0);
    ticks(8);
    press(PV);  push_exp("prev_wrap", 1, 3, 0, 0, 1, 0);
    ticks(16);  push_exp("tick16", 1, 3, 16, 4, 0, 0);
    press(PV);  push_exp("prev_restart", 1, 3, 0, 0, 1, 0);
    press(FL);  push_exp("fwd_long", 1, 3, 120, 30, 0, 0);
    press(FL);
    ticks(15);  push_exp("at_max", 1, 3, 255, 63, 0, 0);

    // Mode 00 on the last song: stop and wrap to song 0
    bus.mode = 2'b00;
    ticks(1);   push_exp("end_of_list", 0, 0, 0, 0, 1, 1);
    ticks(3);   push_exp("stopped_hold", 0, 0, 0, 0, 0, 0);
    press(FS);  push_exp("seek_stopped", 0, 0, 0, 0, 0, 0);
    press(NX);  push_exp("next_stopped", 0, 1, 0, 0, 1, 0);

    // Mode 01 on the last song: wrap and keep playing
    press(PV);
    press(PV);
    press(PP);  push_exp("play_song3", 1, 3, 0, 0, 0, 0);
    goto_max();
    bus.mode = 2'b01;
    ticks(1);   push_exp("repeat_all", 1, 0, 0, 0, 1, 0);

    // Mode 10: replay the same song
    press(PV);
    goto_max();
    bus.mode = 2'b10;
    ticks(1);   push_exp("repeat_one", 1, 3, 0, 0, 1, 0);

    // Mode 11: stop on the same song
    goto_max();
    bus.mode = 2'b11;
    ticks(1);   push_exp("single", 0, 3, 0, 0, 1, 0);

    // rom_data == 0 ends the song early
    press(PP);
    bus.mode = 2'b01;
    ticks(5);
    bus.rom_data = 8'h00;
    ticks(1);
    bus.rom_data = 8'h5A;
    push_exp("rom_zero", 1, 0, 0, 0, 1, 0);

    // next outranks a seek in the same clk
    ticks(4);
    press(NX | FL); push_exp("next_vs_seek", 1, 1, 0, 0, 1, 0);

    // Paused behaviour
    press(PP);  ticks(4);
    push_exp("paused_hold", 0, 1, 0, 0, 0, 0);
    press(NX);  push_exp("next_paused", 0, 2, 0, 0, 1, 0);
    press(FL);
    press(FL);  push_exp("seek_paused", 0, 2, 240, 60, 0, 0);
    press(FS);  push_exp("fwd_overflow", 0, 3, 0, 0, 1, 0);

    // Reset in the middle of playback
    press(PP);
    ticks(6);   push_exp("before_reset", 1, 3, 6, 1, 0, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    push_exp("reset_mid", 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    push_exp("release_mid", 0, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 20 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain: got %0d pending entries, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
